// File: rtl/door_ctrl_multi.sv
// rtl/door_ctrl_multi.sv - multi-channel pressure-mat door sequencer with debounce, hold timer and entry counters
module door_ctrl_multi #(
    parameter int N_DOORS      = 2,
    parameter int DEBOUNCE_CYC = 4,
    parameter int HOLD_CYC     = 16,
    parameter int MOVE_CYC     = 8,
    parameter int CNT_W        = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_DOORS-1:0]         pressure,
    input  logic [N_DOORS-1:0]         lock,
    output logic [N_DOORS-1:0]         door_open,
    output logic [N_DOORS-1:0]         door_moving,
    output logic [N_DOORS-1:0]         door_closed,
    output logic [N_DOORS-1:0]         open_evt,
    output logic [N_DOORS*CNT_W-1:0]   open_count
);
    localparam int MAX_T = (HOLD_CYC > MOVE_CYC) ? HOLD_CYC : MOVE_CYC;
    localparam int TW    = $clog2(MAX_T + 1);
    localparam int DW    = $clog2(DEBOUNCE_CYC + 1);

    localparam logic [TW-1:0] HOLD_T = TW'(HOLD_CYC);
    localparam logic [TW-1:0] MOVE_T = TW'(MOVE_CYC);
    localparam logic [TW-1:0] ONE_T  = TW'(1);
    localparam logic [DW-1:0] DB_TOP = DW'(DEBOUNCE_CYC - 1);

    typedef enum logic [1:0] {
        ST_CLOSED,
        ST_OPENING,
        ST_OPEN,
        ST_CLOSING
    } state_t;

    for (genvar g = 0; g < N_DOORS; g++) begin : g_door
        logic             sync1_q, sync2_q;
        logic             db_q, db_d;
        logic [DW-1:0]    dcnt_q, dcnt_d;
        state_t           state_q, state_d;
        logic [TW-1:0]    tmr_q, tmr_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             evt_q, evt_d;
        logic             open_q, moving_q, closed_q;

        always_comb begin
            db_d   = db_q;
            dcnt_d = '0;
            if (sync2_q != db_q) begin
                if (dcnt_q == DB_TOP) begin
                    db_d = sync2_q;
                end else begin
                    dcnt_d = dcnt_q + 1'b1;
                end
            end
        end

        // Timers are loaded with N and the state advances on the edge that sees 1,
        // so each timed phase lasts exactly N cycles.
        always_comb begin
            state_d = state_q;
            tmr_d   = tmr_q;
            cnt_d   = cnt_q;
            evt_d   = 1'b0;
            unique case (state_q)
                ST_CLOSED: begin
                    if (db_q && !lock[g]) begin
                        state_d = ST_OPENING;
                        tmr_d   = MOVE_T;
                        evt_d   = 1'b1;
                        if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_OPENING: begin
                    if (tmr_q <= ONE_T) begin
                        state_d = ST_OPEN;
                        tmr_d   = HOLD_T;
                    end else begin
                        tmr_d = tmr_q - 1'b1;
                    end
                end
                ST_OPEN: begin
                    if (db_q) begin
                        tmr_d = HOLD_T;
                    end else if (tmr_q <= ONE_T) begin
                        state_d = ST_CLOSING;
                        tmr_d   = MOVE_T;
                    end else begin
                        tmr_d = tmr_q - 1'b1;
                    end
                end
                ST_CLOSING: begin
                    if (db_q) begin
                        state_d = ST_OPENING;
                        tmr_d   = MOVE_T;
                    end else if (tmr_q <= ONE_T) begin
                        state_d = ST_CLOSED;
                        tmr_d   = '0;
                    end else begin
                        tmr_d = tmr_q - 1'b1;
                    end
                end
                default: begin
                    state_d = ST_CLOSED;
                    tmr_d   = '0;
                end
            endcase
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                sync1_q  <= 1'b0;
                sync2_q  <= 1'b0;
                db_q     <= 1'b0;
                dcnt_q   <= '0;
                state_q  <= ST_CLOSED;
                tmr_q    <= '0;
                cnt_q    <= '0;
                evt_q    <= 1'b0;
                open_q   <= 1'b0;
                moving_q <= 1'b0;
                closed_q <= 1'b1;
            end else begin
                sync1_q  <= pressure[g];
                sync2_q  <= sync1_q;
                db_q     <= db_d;
                dcnt_q   <= dcnt_d;
                state_q  <= state_d;
                tmr_q    <= tmr_d;
                cnt_q    <= cnt_d;
                evt_q    <= evt_d;
                open_q   <= (state_d == ST_OPEN);
                moving_q <= (state_d == ST_OPENING) || (state_d == ST_CLOSING);
                closed_q <= (state_d == ST_CLOSED);
            end
        end

        assign door_open[g]                   = open_q;
        assign door_moving[g]                 = moving_q;
        assign door_closed[g]                 = closed_q;
        assign open_evt[g]                    = evt_q;
        assign open_count[g*CNT_W +: CNT_W]   = cnt_q;
    end
endmodule

// File: tb/tb_door_ctrl_multi.sv
// tb/tb_door_ctrl_multi.sv - directed self-checking bench for door_ctrl_multi
module tb_door_ctrl_multi;
    logic        clk;
    logic        rst_n;
    logic [1:0]  pressure, lock, door_open, door_moving, door_closed, open_evt;
    logic [15:0] open_count;
    logic [1:0]  pressure_s, lock_s, open_s, moving_s, closed_s, evt_s;
    logic [3:0]  count_s;

    int total = 0;
    int bad   = 0;

    localparam logic [2:0] CL = 3'b001;
    localparam logic [2:0] MV = 3'b010;
    localparam logic [2:0] OP = 3'b100;

    door_ctrl_multi dut (
        .clk(clk), .rst_n(rst_n), .pressure(pressure), .lock(lock),
        .door_open(door_open), .door_moving(door_moving), .door_closed(door_closed),
        .open_evt(open_evt), .open_count(open_count)
    );

    door_ctrl_multi #(.CNT_W(2)) dut_s (
        .clk(clk), .rst_n(rst_n), .pressure(pressure_s), .lock(lock_s),
        .door_open(open_s), .door_moving(moving_s), .door_closed(closed_s),
        .open_evt(evt_s), .open_count(count_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2:0] st0();
        return {door_open[0], door_moving[0], door_closed[0]};
    endfunction

    logic [2:0] exp_st;

    initial begin
        rst_n = 1'b0; pressure = 2'b11; lock = 2'b00;
        pressure_s = 2'b00; lock_s = 2'b00;

        for (int i = 1; i <= 5; i++) begin
            tick();
            check($sformatf("rst_closed@%0d", i), 32'(door_closed), 32'd3);
            check($sformatf("rst_count@%0d", i), 32'(open_count), 32'd0);
            check($sformatf("rst_evt@%0d", i), 32'(open_evt), 32'd0);
        end
        check("rst_open", 32'(door_open), 32'd0);
        check("rst_moving", 32'(door_moving), 32'd0);
        rst_n = 1'b1; pressure = 2'b00;

        // 3-cycle glitch must never open the door
        for (int e = 1; e <= 12; e++) begin
            pressure[0] = (e <= 3);
            tick();
            check($sformatf("glitch_closed@%0d", e), 32'(door_closed[0]), 32'd1);
            check($sformatf("glitch_evt@%0d", e), 32'(open_evt[0]), 32'd0);
        end

        // normal cycle: press edges 1..15, release at 16
        for (int e = 1; e <= 46; e++) begin
            pressure[0] = (e < 16);
            tick();
            exp_st = (e < 7) ? CL : (e < 15) ? MV : (e < 37) ? OP : (e < 45) ? MV : CL;
            check($sformatf("norm_st@%0d", e), 32'(st0()), 32'(exp_st));
            check($sformatf("norm_evt@%0d", e), 32'(open_evt[0]), 32'(e == 7));
        end
        check("norm_count0", 32'(open_count[7:0]), 32'd1);
        check("norm_door1_closed", 32'(door_closed[1]), 32'd1);

        // obstruction: second press lands while CLOSING and re-opens without an event
        for (int e = 1; e <= 83; e++) begin
            pressure[0] = (e < 16) || (e >= 38 && e < 53);
            tick();
            exp_st = (e < 7) ? CL : (e < 15) ? MV : (e < 37) ? OP : (e < 52) ? MV :
                     (e < 74) ? OP : (e < 82) ? MV : CL;
            check($sformatf("obst_st@%0d", e), 32'(st0()), 32'(exp_st));
            check($sformatf("obst_evt@%0d", e), 32'(open_evt[0]), 32'(e == 7));
        end
        check("obst_count0", 32'(open_count[7:0]), 32'd2);

        // lock on door1 with pressure held
        lock[1] = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            pressure[1] = 1'b1;
            tick();
            check($sformatf("lock1_closed@%0d", e), 32'(door_closed[1]), 32'd1);
            check($sformatf("lock1_evt@%0d", e), 32'(open_evt[1]), 32'd0);
        end
        pressure[1] = 1'b0;
        for (int e = 1; e <= 10; e++) tick();
        lock[1] = 1'b0;
        tick();
        check("lock1_count", 32'(open_count[15:8]), 32'd0);
        check("lock1_closed_end", 32'(door_closed[1]), 32'd1);

        // lock on door0 raised while OPEN, later press held until unlock
        for (int e = 1; e <= 104; e++) begin
            pressure[0] = (e < 16) || (e >= 50 && e < 72);
            lock[0]     = (e >= 20 && e < 71);
            tick();
            exp_st = (e < 7) ? CL : (e < 15) ? MV : (e < 37) ? OP : (e < 45) ? MV :
                     (e < 71) ? CL : (e < 79) ? MV : (e < 95) ? OP : (e < 103) ? MV : CL;
            check($sformatf("lock0_st@%0d", e), 32'(st0()), 32'(exp_st));
            check($sformatf("lock0_evt@%0d", e), 32'(open_evt[0]), 32'(e == 7 || e == 71));
        end
        check("lock0_count", 32'(open_count[7:0]), 32'd4);

        // reset while door0 OPEN
        for (int e = 1; e <= 15; e++) begin
            pressure[0] = 1'b1;
            tick();
        end
        check("midrst_pre_open", 32'(door_open[0]), 32'd1);
        pressure[0] = 1'b0;
        rst_n = 1'b0;
        tick();
        check("midrst_closed", 32'(door_closed), 32'd3);
        check("midrst_open", 32'(door_open), 32'd0);
        check("midrst_count", 32'(open_count), 32'd0);
        check("midrst_evt", 32'(open_evt), 32'd0);
        rst_n = 1'b1;
        tick();

        // saturation with CNT_W=2, door1 left idle
        for (int c = 1; c <= 5; c++) begin
            for (int e = 1; e <= 46; e++) begin
                pressure_s[0] = (e < 16);
                tick();
                if (e == 7) check($sformatf("sat_evt_c%0d", c), 32'(evt_s[0]), 32'd1);
            end
            check($sformatf("sat_count0_c%0d", c), 32'(count_s[1:0]), (c < 3) ? c : 3);
            check($sformatf("sat_count1_c%0d", c), 32'(count_s[3:2]), 32'd0);
            check($sformatf("sat_closed_c%0d", c), 32'(closed_s), 32'd3);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
